// File: rtl/drum_pattern_sequencer_pkg.sv
// Shared types and default sizing for the drum pattern sequencer.
// Sequencer state plus the default voice/step counts used by the block and its bus.
package drum_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    localparam int DEF_NUM_VOICES = 4;
    localparam int DEF_NUM_STEPS  = 16;
    localparam int STEP_W         = $clog2(DEF_NUM_STEPS);

endpackage

// File: rtl/drum_pattern_sequencer_if.sv
// Pattern write bus: the controller (master) loads one voice's step pattern per strobe.
interface drum_pattern_sequencer_if
    import drum_seq_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int NUM_STEPS  = DEF_NUM_STEPS
);
    localparam int VOICE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic                 wr_en;
    logic [VOICE_W-1:0]   wr_voice;
    logic [NUM_STEPS-1:0] wr_pattern;

    modport master (output wr_en, output wr_voice, output wr_pattern);
    modport slave  (input  wr_en, input  wr_voice, input  wr_pattern);

endinterface

// File: rtl/drum_pattern_sequencer_step_tick_gen.sv
// Tempo divider: emits a step tick every max(tick_div,1)+1 cycles while enabled,
// with the first enabled cycle always ticking so playback starts on step 0 immediately.
module step_tick_gen #(
    parameter int TICK_DIV_BITS = 24
) (
    input  logic                     mclk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [TICK_DIV_BITS-1:0] tick_div,
    output logic                     tick,
    output logic                     tick_next
);
    logic [TICK_DIV_BITS-1:0] div_cnt;
    logic [TICK_DIV_BITS-1:0] eff_div;
    logic                     armed;

    // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        eff_div   = (tick_div == '0) ? TICK_DIV_BITS'(1) : tick_div;
        tick_next = enable && (!armed || div_cnt >= eff_div);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge mclk) begin
        if (!rst || !enable) begin
            div_cnt <= '0;
            tick    <= 1'b0;
            armed   <= 1'b0;
        end else begin
            armed   <= 1'b1;
            tick    <= tick_next;
            div_cnt <= tick_next ? '0 : div_cnt + TICK_DIV_BITS'(1);
        end
    end

endmodule

// File: rtl/drum_pattern_sequencer.sv
// Step sequencer driving the one-shot drum voices: tempo divider, step counter,
// per-voice pattern storage and muted, registered trigger pulses.
module drum_pattern_sequencer
    import drum_seq_pkg::*;
#(
    parameter int NUM_VOICES    = DEF_NUM_VOICES,
    parameter int NUM_STEPS     = DEF_NUM_STEPS,
    parameter int TICK_DIV_BITS = 24
) (
    input  logic                         mclk,
    input  logic                         rst,
    input  logic                         run,
    input  logic [TICK_DIV_BITS-1:0]     tick_div,
    input  logic [NUM_VOICES-1:0]        mute,
    drum_pattern_sequencer_if.slave      wr_bus,
    output logic [NUM_VOICES-1:0]        trig,
    output logic                         step_strobe,
    output logic [$clog2(NUM_STEPS)-1:0] step_idx,
    output logic                         busy
);
    localparam int STEP_BITS = $clog2(NUM_STEPS);

    seq_state_t           state;
    logic [NUM_STEPS-1:0] pattern [NUM_VOICES];
    logic [STEP_BITS-1:0] eval_step;
    logic [NUM_VOICES-1:0] hits;
    logic                 tick_next;

    step_tick_gen #(.TICK_DIV_BITS(TICK_DIV_BITS)) u_tick (
        .mclk      (mclk),
        .rst       (rst),
        .enable    (run),
        .tick_div  (tick_div),
        .tick      (step_strobe),
        .tick_next (tick_next)
    );

    // Leaving IDLE always evaluates step 0; otherwise the step after the current one.
    always_comb begin
        eval_step = (state == RUN) ? step_idx + STEP_BITS'(1) : '0;
        hits      = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            hits[v] = pattern[v][eval_step] & ~mute[v];
        end
    end

    always_ff @(posedge mclk) begin
        if (!rst) begin
            state    <= IDLE;
            step_idx <= '0;
            trig     <= '0;
            busy     <= 1'b0;
            // NOTE: patterns live in a small flop array, not a RAM, so they are cleared by reset too.
            for (int v = 0; v < NUM_VOICES; v++) begin
                pattern[v] <= '0;
            end
        end else begin
            // Same-cycle evaluations above read the old pattern; the write lands at this edge.
            if (wr_bus.wr_en && int'(wr_bus.wr_voice) < NUM_VOICES) begin
                pattern[wr_bus.wr_voice] <= wr_bus.wr_pattern;
            end

            if (!run) begin
                state    <= IDLE;
                busy     <= 1'b0;
                step_idx <= '0;
                trig     <= '0;
            end else begin
                state <= RUN;
                busy  <= 1'b1;
                if (tick_next) begin
                    step_idx <= eval_step;
                    trig     <= hits;
                end else begin
                    trig     <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_drum_pattern_sequencer.sv
// Self-checking bench for drum_pattern_sequencer: directed scenarios plus randomized
// traffic, all compared against a step-level behavioural model.
module tb_drum_pattern_sequencer;
    localparam int NV = 3;
    localparam int NS = 16;
    localparam int SB = 4;
    localparam int TB = 8;

    logic          mclk = 1'b0;
    logic          rst;
    logic          run;
    logic [TB-1:0] tick_div;
    logic [NV-1:0] mute;
    logic [NV-1:0] trig;
    logic          step_strobe;
    logic [SB-1:0] step_idx;
    logic          busy;

    drum_pattern_sequencer_if #(.NUM_VOICES(NV), .NUM_STEPS(NS)) bus ();

    drum_pattern_sequencer #(.NUM_VOICES(NV), .NUM_STEPS(NS), .TICK_DIV_BITS(TB)) dut (
        .mclk        (mclk),
        .rst         (rst),
        .run         (run),
        .tick_div    (tick_div),
        .mute        (mute),
        .wr_bus      (bus),
        .trig        (trig),
        .step_strobe (step_strobe),
        .step_idx    (step_idx),
        .busy        (busy)
    );

    always #5 mclk = ~mclk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: "playing" flag, current step, cycles since the last step.
    logic [NS-1:0] m_pat [NV];
    logic          m_busy;
    int            m_step;
    int            m_cnt;
    logic          m_strobe;
    logic [NV-1:0] m_trig;

    task automatic model_edge();
        int  ed;
        logic fire;
        if (!rst) begin
            m_busy = 1'b0; m_step = 0; m_cnt = 0; m_strobe = 1'b0; m_trig = '0;
            for (int v = 0; v < NV; v++) m_pat[v] = '0;
        end else begin
            ed = (tick_div == 0) ? 1 : int'(tick_div);
            if (!run) begin
                m_busy = 1'b0; m_step = 0; m_cnt = 0; m_strobe = 1'b0; m_trig = '0;
            end else begin
                if (!m_busy) begin
                    fire = 1'b1; m_step = 0; m_cnt = 0;
                end else if (m_cnt >= ed) begin
                    fire = 1'b1; m_step = (m_step + 1) % NS; m_cnt = 0;
                end else begin
                    fire = 1'b0; m_cnt = m_cnt + 1;
                end
                m_busy   = 1'b1;
                m_strobe = fire;
                for (int v = 0; v < NV; v++)
                    m_trig[v] = fire && m_pat[v][m_step] && !mute[v];
            end
            if (bus.wr_en && int'(bus.wr_voice) < NV) m_pat[bus.wr_voice] = bus.wr_pattern;
        end
    endtask

    task automatic clk_step();
        model_edge();
        @(posedge mclk);
        #1;
    endtask

    task automatic write_pat(input int v, input logic [NS-1:0] p);
        bus.wr_en = 1'b1; bus.wr_voice = 2'(v); bus.wr_pattern = p;
        clk_step();
        bus.wr_en = 1'b0;
    endtask

    task automatic stop_seq();
        run = 1'b0;
        clk_step();
    endtask

    task automatic test_reset();
        rst = 1'b0; run = 1'b0; tick_div = '0; mute = '0;
        bus.wr_en = 1'b0; bus.wr_voice = '0; bus.wr_pattern = '0;
        clk_step(); clk_step();
        rst = 1'b1;
        clk_step();
        checks++; if (trig !== '0) begin errors++; $display("FAIL reset_trig: got %b want 0", trig); end
        checks++; if (step_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", step_strobe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (step_idx !== '0) begin errors++; $display("FAIL reset_step_idx: got %0d want 0", step_idx); end
    endtask

    task automatic test_basic_playback();
        int t1 = -1;
        int t0b = -1;
        tick_div = 8'd9;
        write_pat(0, 16'h0001);
        write_pat(1, 16'h0100);
        run = 1'b1;
        clk_step();
        checks++;
        if (!(trig[0] === 1'b1 && step_strobe === 1'b1 && busy === 1'b1)) begin
            errors++; $display("FAIL basic_first_trig: trig=%b strobe=%b busy=%b want trig[0]=1 strobe=1 busy=1", trig, step_strobe, busy);
        end
        for (int i = 1; i <= 170; i++) begin
            clk_step();
            if (trig[1] === 1'b1 && t1 < 0) t1 = i;
            if (trig[0] === 1'b1 && t0b < 0) t0b = i;
            checks++;
            if ({trig, step_strobe, busy} !== {m_trig, m_strobe, m_busy} || int'(step_idx) != m_step) begin
                errors++; $display("FAIL basic_cycle%0d: trig=%b strobe=%b idx=%0d want trig=%b strobe=%b idx=%0d",
                                   i, trig, step_strobe, step_idx, m_trig, m_strobe, m_step);
            end
        end
        checks++; if (t1 != 80) begin errors++; $display("FAIL basic_voice1_offset: got %0d want 80", t1); end
        checks++; if (t0b != 160) begin errors++; $display("FAIL basic_voice0_repeat: got %0d want 160", t0b); end
        stop_seq();
    endtask

    task automatic test_divider_clamp();
        logic prev_trig = 1'b0;
        tick_div = '0;
        write_pat(0, 16'hFFFF);
        run = 1'b1;
        for (int i = 0; i < 40; i++) begin
            clk_step();
            checks++;
            if (step_strobe !== ((i % 2) == 0)) begin
                errors++; $display("FAIL clamp_strobe_cycle%0d: got %b want %b", i, step_strobe, (i % 2) == 0);
            end
            checks++;
            if (prev_trig && trig[0]) begin
                errors++; $display("FAIL clamp_trig_held_cycle%0d: trig[0] high two cycles, want pulse", i);
            end
            prev_trig = trig[0];
        end
        stop_seq();
    endtask

    task automatic test_write_collision();
        bit found = 0;
        int hits = 0;
        tick_div = 8'd3;
        write_pat(0, 16'h0000);
        write_pat(1, 16'h0000);
        write_pat(2, 16'h0008);
        run = 1'b1;
        for (int i = 0; i < 200 && !found; i++) begin
            clk_step();
            if (step_strobe === 1'b1 && step_idx === 4'd2) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL collision_reach_step2: timed out, want step 2 strobe"); end
        clk_step(); clk_step(); clk_step();
        write_pat(2, 16'h0000);
        checks++;
        if (!(trig[2] === 1'b1 && step_idx === 4'd3 && step_strobe === 1'b1)) begin
            errors++; $display("FAIL collision_old_pattern: trig=%b idx=%0d strobe=%b want trig[2]=1 idx=3 strobe=1", trig, step_idx, step_strobe);
        end
        for (int i = 0; i < 4 * NS; i++) begin
            clk_step();
            if (trig[2] === 1'b1) hits++;
        end
        checks++; if (hits != 0) begin errors++; $display("FAIL collision_new_pattern: %0d hits want 0", hits); end
        stop_seq();
    endtask

    task automatic test_stop_restart();
        bit found = 0;
        tick_div = 8'd2;
        write_pat(0, 16'h0001);
        run = 1'b1;
        for (int i = 0; i < 200 && !found; i++) begin
            clk_step();
            if (step_strobe === 1'b1 && step_idx === 4'd5) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL stop_reach_step5: timed out, want step 5 strobe"); end
        run = 1'b0;
        clk_step();
        checks++;
        if ({busy, step_strobe, trig} !== '0 || step_idx !== '0) begin
            errors++; $display("FAIL stop_outputs: busy=%b strobe=%b trig=%b idx=%0d want all 0", busy, step_strobe, trig, step_idx);
        end
        run = 1'b1;
        clk_step();
        checks++;
        if (!(trig[0] === 1'b1 && step_strobe === 1'b1 && step_idx === '0 && busy === 1'b1)) begin
            errors++; $display("FAIL restart_step0: trig=%b strobe=%b idx=%0d busy=%b want trig[0]=1 strobe=1 idx=0 busy=1", trig, step_strobe, step_idx, busy);
        end
        stop_seq();
    endtask

    task automatic test_mute_invalid();
        int c0 = 0;
        int c1 = 0;
        int c2 = 0;
        tick_div = 8'd1;
        write_pat(0, 16'h1111);
        write_pat(1, 16'h1111);
        write_pat(2, 16'h0000);
        write_pat(3, 16'hFFFF);
        mute = 3'b010;
        run = 1'b1;
        for (int i = 0; i < 2 * NS; i++) begin
            clk_step();
            c0 += int'(trig[0]); c1 += int'(trig[1]); c2 += int'(trig[2]);
        end
        checks++; if (c0 != 4) begin errors++; $display("FAIL mute_voice0_hits: got %0d want 4", c0); end
        checks++; if (c1 != 0) begin errors++; $display("FAIL mute_voice1_hits: got %0d want 0", c1); end
        checks++; if (c2 != 0) begin errors++; $display("FAIL invalid_write_voice2_hits: got %0d want 0", c2); end
        mute = '0;
        stop_seq();
    endtask

    task automatic test_midrun_reduce_and_reset();
        int hits = 0;
        tick_div = 8'd99;
        write_pat(0, 16'hFFFF);
        run = 1'b1;
        clk_step();
        for (int i = 0; i < 50; i++) clk_step();
        checks++; if (m_cnt != 50 || step_strobe !== 1'b0) begin errors++; $display("FAIL midrun_setup: cnt=%0d strobe=%b want cnt 50 strobe 0", m_cnt, step_strobe); end
        tick_div = 8'd4;
        clk_step();
        checks++;
        if (!(step_strobe === 1'b1 && step_idx === 4'd1 && trig[0] === 1'b1)) begin
            errors++; $display("FAIL midrun_reduce: strobe=%b idx=%0d trig=%b want strobe=1 idx=1 trig[0]=1", step_strobe, step_idx, trig);
        end
        rst = 1'b0;
        clk_step();
        checks++;
        if ({busy, step_strobe, trig} !== '0 || step_idx !== '0) begin
            errors++; $display("FAIL midrun_reset_outputs: busy=%b strobe=%b trig=%b idx=%0d want all 0", busy, step_strobe, trig, step_idx);
        end
        rst = 1'b1;
        tick_div = 8'd1;
        for (int i = 0; i < 2 * NS; i++) begin
            clk_step();
            if (trig !== '0) hits++;
        end
        checks++; if (hits != 0) begin errors++; $display("FAIL reset_clears_patterns: %0d trig cycles want 0", hits); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_restart_busy: got %b want 1", busy); end
        stop_seq();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) run = ~run;
            if ($urandom_range(0, 29) == 0) tick_div = TB'($urandom_range(0, 5));
            if ($urandom_range(0, 19) == 0) mute = NV'($urandom);
            bus.wr_en      = ($urandom_range(0, 7) == 0);
            bus.wr_voice   = 2'($urandom_range(0, 3));
            bus.wr_pattern = NS'($urandom);
            rst            = ($urandom_range(0, 399) != 0);
            clk_step();
            checks++;
            if ({trig, step_strobe, busy} !== {m_trig, m_strobe, m_busy} || int'(step_idx) != m_step) begin
                errors++; $display("FAIL random_cycle%0d: trig=%b strobe=%b busy=%b idx=%0d want trig=%b strobe=%b busy=%b idx=%0d",
                                   i, trig, step_strobe, busy, step_idx, m_trig, m_strobe, m_busy, m_step);
            end
        end
        bus.wr_en = 1'b0;
        rst = 1'b1;
        stop_seq();
    endtask

    initial begin
        test_reset();
        test_basic_playback();
        test_divider_clamp();
        test_write_collision();
        test_stop_restart();
        test_mute_invalid();
        test_midrun_reduce_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/drum_pattern_sequencer.md
# drum_pattern_sequencer

Step sequencer that fires the one-shot drum voices (808 kick, snare, future hihat) from per-voice step patterns at a programmable tempo. It sits upstream of the `src_oneshot_*` voice modules; each `trig` bit drives one voice's `trig` input. It owns the tempo divider, the step counter and the pattern storage, and it is the only source of drum triggers in the design.

## Interface
- `NUM_VOICES`, default 4: number of drum voices; one trigger bit and one pattern per voice.
- `NUM_STEPS`, default 16: pattern length in steps. Must be a power of 2 and at least 2.
- `TICK_DIV_BITS`, default 24: width of the tempo divider.
- `mclk` (in, 1): master clock, 256x the sample rate. Single clock domain.
- `rst` (in, 1): reset, synchronous, active-low.
- `run` (in, 1): level; 1 = play, 0 = stop.
- `tick_div` (in, `TICK_DIV_BITS`): `mclk` cycles per step, minus 1. Sampled live every cycle.
- `mute` (in, `NUM_VOICES`): per-voice mute, applied when each step is evaluated.
- `wr_en` (in, 1): pattern write strobe.
- `wr_voice` (in, `$clog2(NUM_VOICES)`): voice whose pattern is written.
- `wr_pattern` (in, `NUM_STEPS`): new pattern; bit `s` = hit on step `s`.
- `trig` (out, `NUM_VOICES`): registered trigger pulses, one cycle wide.
- `step_strobe` (out, 1): registered; high for one cycle on each step boundary.
- `step_idx` (out, `$clog2(NUM_STEPS)`): current step, registered.
- `busy` (out, 1): high while in RUN.

## Operation
- **Reset (`rst`=0):**
  - State is IDLE.
  - Divider count and `step_idx` are 0.
  - All patterns are 0.
  - `trig`, `step_strobe` and `busy` are 0.
- **Effective divider:** `eff_div = max(tick_div, 1)`. A step therefore lasts at least 2 cycles, so `trig` can never be held high continuously.
- **IDLE, `run`=0:** all outputs stay 0 and `step_idx` stays 0.
- **IDLE, `run`=1 sampled:** the next cycle is the first RUN cycle. In that cycle:
  - `step_idx` = 0, divider count = 0.
  - `step_strobe` = 1, `busy` = 1.
  - `trig[v] = pattern[v][0] & ~mute[v]`.
- **RUN, each cycle:**
  - If `div_cnt >= eff_div`:
    - `div_cnt` <= 0.
    - `step_idx` <= `step_idx + 1`, wrapping modulo `NUM_STEPS` (so `NUM_STEPS-1` goes to 0).
    - `step_strobe` <= 1.
    - `trig[v]` <= `pattern[v][next_step] & ~mute[v]`.
  - Otherwise: `div_cnt` <= `div_cnt + 1`, and `trig` and `step_strobe` <= 0.
  - The comparison is `>=` so that lowering `tick_div` mid-run fires the next step on the following cycle instead of waiting for the counter to wrap.
- **RUN, `run`=0 sampled:** the next cycle is IDLE. In that cycle `trig`, `step_strobe` and `busy` are 0, and `step_idx` and `div_cnt` are cleared to 0. A pending step is discarded.
- **Pattern writes:**
  - On `wr_en`=1: `pattern[wr_voice]` <= `wr_pattern`.
  - If `wr_voice >= NUM_VOICES`, the write is ignored.
  - If a write and a step evaluation occur in the same cycle, the evaluation uses the old pattern.
  - Writes are accepted in both IDLE and RUN.
- **Mute** takes effect on the next evaluated step. It never truncates a `trig` pulse already issued.
- **Reset mid-operation:** `rst`=0 in any state forces the full reset values on the next edge, including clearing all patterns.

## Timing
- Latency from `run` sampled high to the first `trig`/`step_strobe`: 1 cycle.
- Step period: `eff_div + 1` cycles, measured from `step_strobe` to `step_strobe`.
- `trig` is always exactly 1 cycle wide and coincides with `step_strobe`.
- Pattern write to visibility: a write in cycle N affects evaluations in cycle N+1 and later.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- **Package `drum_seq_pkg`:**
  - `seq_state_t` enum: `IDLE`, `RUN`.
  - Default constants for `NUM_VOICES` and `NUM_STEPS`.
  - `STEP_W = $clog2(NUM_STEPS)`.
- **Sub-module `step_tick_gen`:** holds the divider counter and the `eff_div` clamp. Inputs: `mclk`, `rst`, `enable`, `tick_div`. Output: registered `tick`, with `tick` forced on the first enabled cycle.
- **Top level:** FSM, step counter, pattern register array, and the trigger/mute logic.

## Test plan
- **Basic pattern playback:** reset, write voice 0 = `16'h0001` and voice 1 = `16'h0100`, `tick_div`=9, `run`=1. Expect:
  - `trig[0]` on the 1st strobe.
  - `trig[1]` exactly 80 cycles later (8 steps × 10 cycles).
  - `trig[0]` again 160 cycles after the first.
- **Divider clamp:** `tick_div`=0, pattern all ones. Expect `step_strobe` every 2 cycles and `trig` never high for 2 consecutive cycles.
- **Write/strobe collision:** `wr_en` lands in the same cycle a step-3 evaluation occurs, with old bit 3 = 1 and new = 0. Expect `trig` fired for that step 3, and no hit on step 3 of the next loop.
- **Stop and restart:** deassert `run` at step 5. Expect `busy`=0, `step_idx`=0 and no `trig` on the following cycle. Reassert `run`: expect the step-0 `trig` 1 cycle later.
- **Mute and invalid voice:** with `mute[1]`=1, voice 1 produces no `trig` while voice 0 is unaffected. A write to `wr_voice`=`NUM_VOICES` (out of range) leaves all patterns unchanged.
- **Mid-run `tick_div` reduction and reset:** drop `tick_div` from 99 to 4 while `div_cnt`=50. Expect a strobe on the next cycle. Then assert `rst`=0 mid-run. Expect every output at its reset value and patterns read back as zero (no `trig` after restart).
